// File: rtl/mux_n_stream_pkg.sv
// Shared definitions for the N-channel stream multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   wrap_inc()           : channel index increment, wrapping at n-1 back to 0.
package mux_n_stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Next channel index after idx in a ring of n channels.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx >= n - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_n_stream_rr_pick.sv
// Rotate-priority finder: returns the first valid channel at or after ptr,
// wrapping modulo N.
//   valid       : per-channel request vector
//   ptr         : search start index
//   grant       : chosen channel index (0 when nothing is valid)
//   grant_valid : at least one channel is valid
module rr_pick
    import mux_n_stream_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_valid
);

    logic [SELW-1:0] idx;

    // Walk the ring once from ptr; the first hit wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = (32'(ptr) < N) ? ptr : '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!grant_valid && valid[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
            idx = SELW'(wrap_inc(32'(idx), N));
        end
    end

endmodule

// File: rtl/mux_n_stream.sv
// N-channel, W-bit stream multiplexer with valid/ready handshakes and a
// registered output stage. Fixed (sel) or round-robin channel selection.
// Optional macro MUX_N_STREAM_LOCK_EN adds in_last/out_last and locks the
// grant onto one channel until its last beat has transferred.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_valid    : packed channel data (channel i at [i*W +: W]), valids
//   in_ready            : per-channel ready (combinational, one-hot or zero)
//   sel, mode           : fixed select index, 0 = fixed / 1 = round-robin
//   out_data/out_valid  : registered output beat
//   out_ready           : consumer ready
//   out_chan            : registered source channel of out_data
//   in_last/out_last    : packet end markers (MUX_N_STREAM_LOCK_EN only)
module mux_n_stream
    import mux_n_stream_pkg::*;
#(
    parameter int unsigned  N    = 4,
    parameter int unsigned  W    = 2,
    localparam int unsigned SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SELW-1:0] out_chan
`ifdef MUX_N_STREAM_LOCK_EN
    ,
    input  logic [N-1:0]    in_last,
    output logic            out_last
`endif
);

    logic            load_en;
    logic            take;
    logic            grant_valid;
    logic            rr_valid;
    logic [SELW-1:0] grant;
    logic [SELW-1:0] rr_grant;
    logic [SELW-1:0] rr_ptr;
    logic            rr_adv;
    logic [W-1:0]    ch_data [N];

`ifdef MUX_N_STREAM_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_chan;
`endif

    // Unpacked view of the channel data bus.
    for (genvar g = 0; g < int'(N); g++) begin : g_split
        assign ch_data[g] = in_data[g*W +: W];
    end

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .valid       (in_valid),
        .ptr         (rr_ptr),
        .grant       (rr_grant),
        .grant_valid (rr_valid)
    );

    // Grant selection; an out-of-range sel yields no grant.
    always_comb begin
        grant       = sel;
        grant_valid = (32'(sel) < N) && in_valid[sel];
        if (mode == MODE_RR) begin
            grant       = rr_grant;
            grant_valid = rr_valid;
        end
`ifdef MUX_N_STREAM_LOCK_EN
        if (locked) begin
            grant       = lock_chan;
            grant_valid = in_valid[lock_chan];
        end
`endif
    end

    // Handshake: a beat moves when the output register can take it.
    always_comb begin
        load_en  = !out_valid || out_ready;
        take     = !rst && load_en && grant_valid;
        in_ready = '0;
        if (take) begin
            in_ready[grant] = 1'b1;
        end
`ifdef MUX_N_STREAM_LOCK_EN
        rr_adv = take && (mode == MODE_RR) && in_last[grant];
`else
        rr_adv = take && (mode == MODE_RR);
`endif
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_chan  <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load_en) begin
                if (take) begin
                    out_data  <= ch_data[grant];
                    out_chan  <= grant;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (rr_adv) begin
                rr_ptr <= SELW'(wrap_inc(32'(grant), N));
            end
        end
    end

`ifdef MUX_N_STREAM_LOCK_EN
    // Packet lock: hold the grant on a channel until its last beat moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked    <= 1'b0;
            lock_chan <= '0;
            out_last  <= 1'b0;
        end else if (take) begin
            locked    <= !in_last[grant];
            lock_chan <= grant;
            out_last  <= in_last[grant];
        end
    end
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
// Self-checking bench for mux_n_stream: directed stimulus pushes expected
// beats into a scoreboard; a monitor pops and compares on each output
// handshake. A second N=3 instance covers the out-of-range select.
// Define MUX_N_STREAM_LOCK_EN to also exercise packet locking.
module tb_mux_n_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic [3:0] in_valid;
    logic [3:0] in_ready;
    logic [1:0] sel;
    logic       mode;
    logic [1:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_chan;

    logic [5:0] d3_in_data;
    logic [2:0] d3_in_valid;
    logic [2:0] d3_in_ready;
    logic [1:0] d3_sel;
    logic       d3_mode;
    logic [1:0] d3_out_data;
    logic       d3_out_valid;
    logic       d3_out_ready;
    logic [1:0] d3_out_chan;

`ifdef MUX_N_STREAM_LOCK_EN
    logic [3:0] in_last;
    logic       out_last;
    logic [2:0] d3_in_last;
    logic       d3_out_last;
`endif

    always #5 clk = ~clk;

    mux_n_stream #(.N(4), .W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
`ifdef MUX_N_STREAM_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    mux_n_stream #(.N(3), .W(2)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .sel       (d3_sel),
        .mode      (d3_mode),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_chan  (d3_out_chan)
`ifdef MUX_N_STREAM_LOCK_EN
        ,
        .in_last   (d3_in_last),
        .out_last  (d3_out_last)
`endif
    );

    typedef struct packed {
        logic [1:0] data;
        logic [1:0] chan;
        logic       last;
    } beat_t;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Channel i carries data 3-i on the main instance.
    task automatic expect_beat(input int ch, input logic last);
        beat_t b;
        b.data = 2'(3 - ch);
        b.chan = 2'(ch);
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle: check in_ready at the falling edge, queue the expected beat.
    task automatic cyc(input string nm, input logic [3:0] rdy_exp, input int ch, input logic last);
        @(negedge clk);
        check(nm, 32'(in_ready), 32'(rdy_exp));
        if (ch >= 0) expect_beat(ch, last);
        tick();
    endtask

    // Monitor: every output handshake must match the oldest queued beat.
    always @(negedge clk) begin
        beat_t e;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got chan %0d data %0d with empty queue", out_chan, out_data);
            end else begin
                e = sb.pop_front();
                check("beat_data", 32'(out_data), 32'(e.data));
                check("beat_chan", 32'(out_chan), 32'(e.chan));
`ifdef MUX_N_STREAM_LOCK_EN
                check("beat_last", 32'(out_last), 32'(e.last));
`endif
            end
        end
    end

    initial begin
        logic [3:0] bp_valid [3];
        bp_valid[0] = 4'b1111;
        bp_valid[1] = 4'b0010;
        bp_valid[2] = 4'b1000;

        rst          = 1'b1;
        in_data      = {2'd0, 2'd1, 2'd2, 2'd3};
        in_valid     = 4'b1111;
        sel          = 2'd2;
        mode         = 1'b0;
        out_ready    = 1'b1;
        d3_in_data   = {2'd2, 2'd1, 2'd0};
        d3_in_valid  = 3'b000;
        d3_sel       = 2'd0;
        d3_mode      = 1'b0;
        d3_out_ready = 1'b1;
`ifdef MUX_N_STREAM_LOCK_EN
        in_last      = 4'b1111;
        d3_in_last   = 3'b111;
`endif

        // Reset held with all inputs valid.
        tick();
        repeat (2) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_chan", 32'(out_chan), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_d3_out_valid", 32'(d3_out_valid), 32'd0);
            tick();
        end
        rst = 1'b0;

        // Fixed select of channel 2, full throughput.
        repeat (4) cyc("fixed_in_ready", 4'b0100, 2, 1'b1);

        // Round-robin over all channels, then over channels 1 and 3.
        mode = 1'b1;
        for (int i = 0; i < 5; i++) cyc("rr_all_in_ready", 4'(1 << (i % 4)), i % 4, 1'b1);
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) cyc("rr_odd_in_ready", (i % 2 == 0) ? 4'b0010 : 4'b1000,
                                        (i % 2 == 0) ? 1 : 3, 1'b1);

        // Backpressure: load channel 0, stall three cycles, resume.
        in_valid = 4'b1111;
        cyc("bp_load", 4'b0001, 0, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = bp_valid[k];
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", 32'(out_data), 32'd3);
            check("bp_out_chan", 32'(out_chan), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        cyc("bp_resume", 4'b0100, 2, 1'b1);
        in_valid = 4'b0000;
        cyc("bp_idle", 4'b0000, -1, 1'b1);
        @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 32'd0);
        check("drain_hold_data", 32'(out_data), 32'd1);
        check("drain_hold_chan", 32'(out_chan), 32'd2);
        tick();

        // N=3: valid select, then out-of-range select.
        d3_in_valid = 3'b111;
        d3_sel      = 2'd1;
        @(negedge clk);
        check("d3_in_ready_sel1", 32'(d3_in_ready), 32'b010);
        tick();
        d3_sel = 2'd3;
        @(negedge clk);
        check("d3_in_ready_sel3", 32'(d3_in_ready), 32'd0);
        check("d3_out_valid_loaded", 32'(d3_out_valid), 32'd1);
        check("d3_out_data", 32'(d3_out_data), 32'd1);
        check("d3_out_chan", 32'(d3_out_chan), 32'd1);
        tick();
        @(negedge clk);
        check("d3_out_valid_drained", 32'(d3_out_valid), 32'd0);
        tick();
        d3_in_valid = 3'b000;

`ifdef MUX_N_STREAM_LOCK_EN
        // Packet lock: channel 1 sends three beats while channel 2 waits.
        mode     = 1'b1;
        in_valid = 4'b0110;
        in_last  = 4'b0100;
        cyc("lock_beat1", 4'b0010, 1, 1'b0);
        cyc("lock_beat2", 4'b0010, 1, 1'b0);
        in_last = 4'b0110;
        cyc("lock_beat3", 4'b0010, 1, 1'b1);
        in_valid = 4'b0100;
        in_last  = 4'b0100;
        cyc("lock_next", 4'b0100, 2, 1'b1);
        in_last = 4'b1111;
`endif

        in_valid = 4'b0000;
        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
